// File: rtl/cpu_sequencer_if.sv
// Instruction- and data-memory handshake bundle between the CPU sequencer and its memories.
interface cpu_sequencer_if #(
  parameter int PC_WIDTH = 8
);
  logic                imem_req;
  logic [PC_WIDTH-1:0] imem_addr;
  logic                imem_ack;
  logic [7:0]          imem_rdata;
  logic                dmem_req;
  logic                dmem_we;
  logic                dmem_ack;

  modport master (
    output imem_req, imem_addr, dmem_req, dmem_we,
    input  imem_ack, imem_rdata, dmem_ack
  );

  modport slave (
    input  imem_req, imem_addr, dmem_req, dmem_we,
    output imem_ack, imem_rdata, dmem_ack
  );
endinterface

// File: rtl/cpu_sequencer.sv
// Multi-cycle fetch/decode/execute sequencer for the 8-bit CPU.
// Define SEQ_ILLEGAL_TRAP_EN to halt on illegal opcodes; otherwise they execute as counted NOPs.
module cpu_sequencer #(
  parameter int PC_WIDTH     = 8,
  parameter int RETIRE_WIDTH = 16
) (
  input  logic                    clk,
  input  logic                    rst_n,
  cpu_sequencer_if.master         bus,
  output logic [7:0]              ir,
  input  logic [1:0]              cu_mem_op,
  input  logic                    cu_write_enable,
  input  logic [3:0]              cu_branch_offset,
  input  logic                    zero_flag,
  output logic                    rf_we,
  output logic                    flags_we,
  output logic [PC_WIDTH-1:0]     pc,
  output logic [2:0]              state,
  output logic                    halted,
  output logic                    illegal,
  output logic [RETIRE_WIDTH-1:0] retired
);

  localparam logic [2:0] S_FETCH  = 3'd0;
  localparam logic [2:0] S_DECODE = 3'd1;
  localparam logic [2:0] S_EXEC   = 3'd2;
  localparam logic [2:0] S_MEM    = 3'd3;
  localparam logic [2:0] S_WB     = 3'd4;
  localparam logic [2:0] S_HALT   = 3'd5;

  localparam logic [3:0] OP_HALT = 4'b0001;
  localparam logic [3:0] OP_BEQ  = 4'b1010;
  localparam logic [3:0] OP_BNE  = 4'b1011;

  logic [2:0]              state_reg, state_next;
  logic [PC_WIDTH-1:0]     pc_reg, pc_next;
  logic [7:0]              ir_reg, ir_next;
  logic                    illegal_reg, illegal_next;
  logic [RETIRE_WIDTH-1:0] retired_reg, retired_next;
  logic                    retire_inc;

  logic [3:0]              opcode;
  logic [15:0]             legal_mask;
  logic                    is_branch;
  logic                    branch_taken;
  logic [PC_WIDTH-1:0]     branch_sext;

  // One bit per opcode: 0001, 0011, 0101 and the whole 1xxx half are legal.
  genvar gi;
  generate
    for (gi = 0; gi < 16; gi++) begin : g_legal
      assign legal_mask[gi] = (gi == 1) || (gi == 3) || (gi == 5) || (gi >= 8);
    end
  endgenerate

  assign opcode       = ir_reg[7:4];
  assign is_branch    = (opcode == OP_BEQ) || (opcode == OP_BNE);
  assign branch_taken = (opcode == OP_BEQ) ? zero_flag : !zero_flag;
  assign branch_sext  = {{(PC_WIDTH-4){cu_branch_offset[3]}}, cu_branch_offset};

  always_comb begin
    state_next   = state_reg;
    pc_next      = pc_reg;
    ir_next      = ir_reg;
    illegal_next = illegal_reg;
    retire_inc   = 1'b0;
    case (state_reg)
      S_FETCH: begin
        if (bus.imem_ack) begin
          ir_next    = bus.imem_rdata;
          pc_next    = pc_reg + PC_WIDTH'(1);
          state_next = S_DECODE;
        end
      end
      S_DECODE: begin
        if (opcode == OP_HALT) begin
          state_next = S_HALT;
          retire_inc = 1'b1;
        end else if (!legal_mask[opcode]) begin
          illegal_next = 1'b1;
`ifdef SEQ_ILLEGAL_TRAP_EN
          state_next   = S_HALT;
`else
          state_next   = S_FETCH;
          retire_inc   = 1'b1;
`endif
        end else if (cu_mem_op != 2'b00) begin
          state_next = S_MEM;
        end else begin
          state_next = S_EXEC;
        end
      end
      S_EXEC: begin
        if (is_branch) begin
          // pc already points past the branch, so the offset is relative to the next instruction.
          if (branch_taken) begin
            pc_next = pc_reg + branch_sext;
          end
          state_next = S_FETCH;
          retire_inc = 1'b1;
        end else begin
          state_next = S_WB;
        end
      end
      S_MEM: begin
        if (bus.dmem_ack) begin
          if (cu_mem_op == 2'b10) begin
            state_next = S_FETCH;
            retire_inc = 1'b1;
          end else begin
            state_next = S_WB;
          end
        end
      end
      S_WB: begin
        state_next = S_FETCH;
        retire_inc = 1'b1;
      end
      S_HALT: begin
        state_next = S_HALT;
      end
      default: begin
        state_next = S_FETCH;
      end
    endcase
    retired_next = retire_inc ? retired_reg + RETIRE_WIDTH'(1) : retired_reg;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_reg   <= S_FETCH;
      pc_reg      <= '0;
      ir_reg      <= '0;
      illegal_reg <= 1'b0;
      retired_reg <= '0;
    end else begin
      state_reg   <= state_next;
      pc_reg      <= pc_next;
      ir_reg      <= ir_next;
      illegal_reg <= illegal_next;
      retired_reg <= retired_next;
    end
  end

  // Strobes decode only the registered state and the control-unit view of ir.
  assign bus.imem_req  = (state_reg == S_FETCH);
  assign bus.imem_addr = pc_reg;
  assign bus.dmem_req  = (state_reg == S_MEM);
  assign bus.dmem_we   = (state_reg == S_MEM) && (cu_mem_op == 2'b10);
  assign rf_we         = (state_reg == S_WB) && cu_write_enable;
  assign flags_we      = (state_reg == S_WB) && (cu_mem_op == 2'b00);
  assign halted        = (state_reg == S_HALT);

  assign ir      = ir_reg;
  assign pc      = pc_reg;
  assign state   = state_reg;
  assign illegal = illegal_reg;
  assign retired = retired_reg;

endmodule

// File: doc/cpu_sequencer.md
# cpu_sequencer

Multi-cycle fetch/decode/execute sequencer for the 8-bit CPU. Owns the program counter and instruction register and drives the instruction-memory handshake. Presents the latched instruction to the combinational control unit, then uses the decode results to step the datapath through execute, memory and write-back. Gates register-file writes and resolves conditional branches and HALT.

## Interface
- `PC_WIDTH`, default 8: program counter and instruction-memory address width.
- `RETIRE_WIDTH`, default 16: width of the retired-instruction counter.

Ports:
- `clk`  in  1  single clock; all state updates on the rising edge.
- `rst_n`  in  1  synchronous, active-low reset.
- `imem_req`  out  1  instruction fetch request.
- `imem_addr`  out  PC_WIDTH  fetch address; equals `pc` while `imem_req` is high.
- `imem_ack`  in  1  fetch complete; `imem_rdata` is valid in the same cycle.
- `imem_rdata`  in  8  fetched instruction.
- `ir`  out  8  instruction register; drives the control unit.
- `cu_mem_op`  in  2  from the control unit: 00 none, 01 LD, 10 ST.
- `cu_write_enable`  in  1  from the control unit: the instruction writes a register.
- `cu_branch_offset`  in  4  from the control unit: sign-extended branch offset.
- `zero_flag`  in  1  ALU zero flag, registered in the datapath.
- `dmem_req`  out  1  data-memory request.
- `dmem_we`  out  1  data-memory write; high only during ST.
- `dmem_ack`  in  1  data access complete.
- `rf_we`  out  1  register-file write strobe, one cycle.
- `flags_we`  out  1  zero-flag update strobe, one cycle.
- `pc`  out  PC_WIDTH  program counter.
- `state`  out  3  FSM state encoding, for debug.
- `halted`  out  1  high in HALT.
- `illegal`  out  1  sticky illegal-opcode flag.
- `retired`  out  RETIRE_WIDTH  count of completed instructions.

## Operation
- FSM states and encodings: FETCH=0, DECODE=1, EXEC=2, MEM=3, WB=4, HALT=5.
- FETCH:
  - `imem_req`=1 and `imem_addr`=`pc`; hold until `imem_ack`.
  - On ack: `ir`<=`imem_rdata`, `pc`<=`pc`+1 (mod 2^PC_WIDTH), go to DECODE.
- DECODE: lasts one cycle so the control-unit outputs settle. Priority, first match wins:
  - opcode `ir[7:4]`=0001 → HALT.
  - illegal opcode → see Configuration.
  - `cu_mem_op`≠00 → MEM.
  - otherwise → EXEC.
- Legal opcodes: 0001, 0011, 0101, 1000–1111.
- EXEC:
  - Branch opcodes: 1010 is taken when `zero_flag`=1; 1011 is taken when `zero_flag`=0.
  - Taken branch: `pc`<=`pc`+sext(`cu_branch_offset`), modulo 2^PC_WIDTH. `pc` here is already the incremented value. Then → FETCH.
  - Not taken: → FETCH with `pc` unchanged.
  - All other opcodes: → WB.
- MEM:
  - `dmem_req`=1; `dmem_we`=1 when `cu_mem_op`=10. Hold until `dmem_ack`.
  - On ack: LD → WB; ST → FETCH.
  - `cu_mem_op`=11 is treated as LD.
- WB: `rf_we`=`cu_write_enable`, `flags_we`=1 for non-memory opcodes, then → FETCH.
- `retired` increments by 1 on every transition into FETCH that follows DECODE, EXEC, MEM or WB. It wraps at its maximum. The HALT instruction itself is counted on entry to HALT.
- HALT is terminal. Only `rst_n`=0 leaves it.

## Timing
- Reset values: `state`=FETCH, `pc`=0, `ir`=0, `retired`=0, `illegal`=0, `halted`=0.
- All strobes are low during reset and in the first cycle after it; `imem_req` rises in the first cycle after reset.
- `imem_req`, `dmem_req`, `dmem_we`, `rf_we`, `flags_we` and `halted` are Moore outputs of the registered state and `ir`.
- Latencies, counted from `ir` load with zero-wait memories (ack in the request cycle):
  - ALU or immediate instruction: 4 cycles (FETCH, DECODE, EXEC, WB).
  - Branch: 3 cycles.
  - ST: 3 cycles.
  - LD: 4 cycles.
- Each wait cycle on a handshake adds exactly one cycle. The request is held stable and the address does not change while waiting.
- Reset mid-handshake: the request drops in the cycle after the reset edge. Any late ack is ignored unless the FSM is in the matching state.
- `rf_we` and `flags_we` are never high in the same cycle as `imem_req` or `dmem_req`.
- PC wrap: a fetch at 0xFF leaves `pc`=0x00. A branch from `pc`=0x00 with offset −1 gives 0xFF.

## Configuration
- `SEQ_ILLEGAL_TRAP_EN` defined:
  - An illegal opcode in DECODE sets `illegal`=1 and enters HALT.
  - No write strobes occur.
  - `retired` does not count the illegal instruction.
- `SEQ_ILLEGAL_TRAP_EN` undefined:
  - An illegal opcode is a NOP: DECODE → FETCH, `illegal` is still set sticky.
  - No strobes occur; the instruction is counted in `retired`.

## Test plan
- Reset, then program `0x85` (ADDI), zero-wait memory → `imem_addr`=0, `rf_we` pulses in cycle 4, `pc`=1, `retired`=1.
- BEQ `0xA3` with `cu_branch_offset`=0xF (−1), `zero_flag`=1, fetched at `pc`=5 → next `imem_addr`=5. With `zero_flag`=0 → next `imem_addr`=6.
- ST `0xE4` with `dmem_ack` delayed 3 cycles → `dmem_req` and `dmem_we` high for 4 cycles, no `rf_we`, then FETCH.
- HALT `0x10` → `halted`=1 forever, no further `imem_req`, `retired`=1. Then `rst_n`=0 for one cycle → `pc`=0, fetch restarts.
- Opcode `0x00`:
  - With `SEQ_ILLEGAL_TRAP_EN`: `illegal`=1 and `halted`=1.
  - Without: `illegal`=1 and the next fetch is at `pc`+1.
- `rst_n` asserted while in MEM with `dmem_req` high → `dmem_req`=0 on the next edge, `state`=FETCH, `pc`=0.
